change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser.sv | 171 +++++++++++++++++
 tb/tb_change_dispenser.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Coin change dispenser: pays an amount in jiao from a 1/5/10 jiao inventory,
// largest coin first, handshaking each coin with a hopper and guarding it with a watchdog.
module change_dispenser (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_start,
    input  logic [4:0] i_amount,
    input  logic       i_hopper_ack,
    input  logic       i_load,
    input  logic [1:0] i_load_sel,
    input  logic [7:0] i_load_cnt,
    output logic [2:0] o_eject,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_fail,
    output logic       o_jam,
    output logic [4:0] o_remaining,
    output logic [7:0] o_cnt_1,
    output logic [7:0] o_cnt_5,
    output logic [7:0] o_cnt_10
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_EJECT  = 3'd2,
        S_GAP    = 3'd3,
        S_DONE   = 3'd4,
        S_FAIL   = 3'd5
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_coin;
    logic [2:0] w_sel_coin;
    logic [4:0] w_coin_val;
    logic [4:0] r_remaining;
    logic [7:0] r_cnt_1;
    logic [7:0] r_cnt_5;
    logic [7:0] r_cnt_10;
    logic [7:0] r_wdog;
    logic       r_jam;
    logic       w_timeout;

    // Largest coin that fits the remaining amount and is in stock.
    always_comb begin
        w_sel_coin = 3'b000;
        if (r_remaining >= 5'd10 && r_cnt_10 != 8'd0)
            w_sel_coin = 3'b100;
        else if (r_remaining >= 5'd5 && r_cnt_5 != 8'd0)
            w_sel_coin = 3'b010;
        else if (r_cnt_1 != 8'd0)
            w_sel_coin = 3'b001;
    end

    always_comb begin
        case (r_coin)
            3'b001:  w_coin_val = 5'd1;
            3'b010:  w_coin_val = 5'd5;
            3'b100:  w_coin_val = 5'd10;
            default: w_coin_val = 5'd0;
        endcase
    end

    // Watchdog reaches 255 on this edge with no acknowledge: 255 request cycles in total.
    assign w_timeout = (r_state == S_EJECT) && !i_hopper_ack && (r_wdog == 8'd254);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_next = S_SELECT;
            S_SELECT: begin
                if (r_remaining == 5'd0)
                    w_next = S_DONE;
                else if (w_sel_coin != 3'b000)
                    w_next = S_EJECT;
                else
                    w_next = S_FAIL;
            end
            S_EJECT: begin
                if (i_hopper_ack)
                    w_next = S_GAP;
                else if (w_timeout)
                    w_next = S_FAIL;
            end
            S_GAP:    if (!i_hopper_ack) w_next = S_SELECT;
            S_DONE:   w_next = S_IDLE;
            S_FAIL:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_coin      <= 3'b000;
            r_remaining <= 5'd0;
            r_cnt_1     <= 8'd0;
            r_cnt_5     <= 8'd0;
            r_cnt_10    <= 8'd0;
            r_wdog      <= 8'd0;
            r_jam       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_remaining <= i_amount;
                        r_jam       <= 1'b0;
                    end else if (i_load) begin
                        case (i_load_sel)
                            2'b00:   r_cnt_1  <= i_load_cnt;
                            2'b01:   r_cnt_5  <= i_load_cnt;
                            2'b10:   r_cnt_10 <= i_load_cnt;
                            default: ;
                        endcase
                    end
                end
                S_SELECT: begin
                    if (w_next == S_EJECT) begin
                        r_coin <= w_sel_coin;
                        r_wdog <= 8'd0;
                    end
                end
                S_EJECT: begin
                    if (i_hopper_ack) begin
                        // Coin choice guarantees coin <= remaining and count > 0.
                        r_remaining <= r_remaining - w_coin_val;
                        case (r_coin)
                            3'b001:  r_cnt_1  <= r_cnt_1 - 8'd1;
                            3'b010:  r_cnt_5  <= r_cnt_5 - 8'd1;
                            3'b100:  r_cnt_10 <= r_cnt_10 - 8'd1;
                            default: ;
                        endcase
                    end else begin
                        r_wdog <= r_wdog + 8'd1;
                        if (w_timeout)
                            r_jam <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_eject = 3'b000;
        o_busy  = 1'b1;
        o_done  = 1'b0;
        o_fail  = 1'b0;
        case (r_state)
            S_IDLE:  o_busy  = 1'b0;
            S_EJECT: o_eject = r_coin;
            S_DONE:  o_done  = 1'b1;
            S_FAIL:  o_fail  = 1'b1;
            default: ;
        endcase
    end

    assign o_jam       = r_jam;
    assign o_remaining = r_remaining;
    assign o_cnt_1     = r_cnt_1;
    assign o_cnt_5     = r_cnt_5;
    assign o_cnt_10    = r_cnt_10;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: scenario tasks with hand-computed expectations,
// driven and sampled 1 ns after each rising clock edge.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       i_start;
    logic [4:0] i_amount;
    logic       i_hopper_ack;
    logic       i_load;
    logic [1:0] i_load_sel;
    logic [7:0] i_load_cnt;
    logic [2:0] o_eject;
    logic       o_busy, o_done, o_fail, o_jam;
    logic [4:0] o_remaining;
    logic [7:0] o_cnt_1, o_cnt_5, o_cnt_10;

    int n_vec = 0;
    int n_err = 0;

    logic [2:0] ej_seq[$];
    int  eject_cycles, busy_cycles, done_cycle, ack_high_eject;
    bit  done_seen, fail_seen, timed_out;

    always #5 clk = ~clk;

    change_dispenser dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_start      (i_start),
        .i_amount     (i_amount),
        .i_hopper_ack (i_hopper_ack),
        .i_load       (i_load),
        .i_load_sel   (i_load_sel),
        .i_load_cnt   (i_load_cnt),
        .o_eject      (o_eject),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_fail       (o_fail),
        .o_jam        (o_jam),
        .o_remaining  (o_remaining),
        .o_cnt_1      (o_cnt_1),
        .o_cnt_5      (o_cnt_5),
        .o_cnt_10     (o_cnt_10)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_coin(input logic [1:0] sel, input logic [7:0] cnt);
        i_load     = 1'b1;
        i_load_sel = sel;
        i_load_cnt = cnt;
        step();
        i_load = 1'b0;
        $display("load sel=%0d cnt=%0d -> cnt_1=%0d cnt_5=%0d cnt_10=%0d", sel, cnt, o_cnt_1, o_cnt_5, o_cnt_10);
    endtask

    // Starts a payout and plays the hopper: acks each request ack_dly cycles after it
    // appears (0 = never), holding ack for ack_hold cycles. Returns one cycle after DONE/FAIL.
    task automatic run_payout(input logic [4:0] amt, input int ack_dly, input int ack_hold,
                              input bit inject, input int max_cyc);
        int  wait_cnt, hold_left, cyc;
        bit  injected;
        ej_seq.delete();
        done_seen = 0; fail_seen = 0; timed_out = 0;
        eject_cycles = 0; busy_cycles = 0; done_cycle = -1; ack_high_eject = 0;
        wait_cnt = 0; hold_left = 0; injected = 0;
        i_amount = amt;
        i_start  = 1'b1;
        step();
        cyc = 1;
        i_start = 1'b0;
        i_load  = 1'b0;
        while (1) begin
            if (o_busy) busy_cycles++;
            if (o_done) begin done_seen = 1; done_cycle = cyc; break; end
            if (o_fail) begin fail_seen = 1; break; end
            if (i_hopper_ack) begin
                if (o_eject != 3'b000) ack_high_eject++;
                hold_left--;
                if (hold_left <= 0) i_hopper_ack = 1'b0;
            end else if (o_eject != 3'b000) begin
                eject_cycles++;
                if (inject && !injected) begin
                    injected   = 1;
                    i_start    = 1'b1;
                    i_amount   = 5'd31;
                    i_load     = 1'b1;
                    i_load_sel = 2'b00;
                    i_load_cnt = 8'd9;
                end
                wait_cnt++;
                if (wait_cnt == ack_dly) begin
                    i_hopper_ack = 1'b1;
                    hold_left    = ack_hold;
                    ej_seq.push_back(o_eject);
                    wait_cnt     = 0;
                end
            end
            if (cyc >= max_cyc) begin timed_out = 1; break; end
            step();
            cyc++;
            i_start = 1'b0;
            i_load  = 1'b0;
        end
        i_hopper_ack = 1'b0;
        step();
        n_vec++;
        if (timed_out !== 1'b0) begin
            n_err++;
            $display("FAIL payout_timeout amount=%0d got no done/fail within %0d cycles", amt, max_cyc);
        end
        $display("payout amount=%0d coins=%0d done=%0d fail=%0d rem=%0d jam=%0d", amt, ej_seq.size(), done_seen, fail_seen, o_remaining, o_jam);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%0b exp=0", o_busy); end
        n_vec++; if (o_eject !== 3'b000) begin n_err++; $display("FAIL reset_eject got=%b exp=000", o_eject); end
        n_vec++; if ({o_done, o_fail, o_jam} !== 3'b000) begin n_err++; $display("FAIL reset_flags got=%b exp=000", {o_done, o_fail, o_jam}); end
        n_vec++; if ({o_remaining, o_cnt_1, o_cnt_5, o_cnt_10} !== 29'd0) begin n_err++; $display("FAIL reset_regs got rem=%0d c1=%0d c5=%0d c10=%0d exp all 0", o_remaining, o_cnt_1, o_cnt_5, o_cnt_10); end
        reset_n = 1'b1;
        step();
        $display("reset released");
    endtask

    task automatic test_load();
        load_coin(2'b10, 8'd7);
        load_coin(2'b01, 8'd6);
        load_coin(2'b00, 8'd5);
        n_vec++; if ({o_cnt_10, o_cnt_5, o_cnt_1} !== {8'd7, 8'd6, 8'd5}) begin n_err++; $display("FAIL load_counts got=%0d/%0d/%0d exp=7/6/5", o_cnt_10, o_cnt_5, o_cnt_1); end
        load_coin(2'b11, 8'd99);
        n_vec++; if ({o_cnt_10, o_cnt_5, o_cnt_1} !== {8'd7, 8'd6, 8'd5}) begin n_err++; $display("FAIL load_sel11 got=%0d/%0d/%0d exp=7/6/5", o_cnt_10, o_cnt_5, o_cnt_1); end
    endtask

    task automatic test_payout_17();
        logic [2:0] exp_seq[4];
        exp_seq = '{3'b100, 3'b010, 3'b001, 3'b001};
        load_coin(2'b10, 8'd2);
        load_coin(2'b01, 8'd2);
        load_coin(2'b00, 8'd5);
        run_payout(5'd17, 3, 1, 0, 200);
        n_vec++; if (ej_seq.size() !== 4) begin n_err++; $display("FAIL p17_ncoins got=%0d exp=4", ej_seq.size()); end
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (k < ej_seq.size() && ej_seq[k] !== exp_seq[k]) begin n_err++; $display("FAIL p17_coin%0d got=%b exp=%b", k, ej_seq[k], exp_seq[k]); end
        end
        n_vec++; if (done_seen !== 1'b1 || fail_seen !== 1'b0) begin n_err++; $display("FAIL p17_done got done=%0d fail=%0d exp done=1 fail=0", done_seen, fail_seen); end
        n_vec++; if ({o_cnt_10, o_cnt_5, o_cnt_1} !== {8'd1, 8'd1, 8'd3}) begin n_err++; $display("FAIL p17_counts got=%0d/%0d/%0d exp=1/1/3", o_cnt_10, o_cnt_5, o_cnt_1); end
        n_vec++; if (o_remaining !== 5'd0) begin n_err++; $display("FAIL p17_remaining got=%0d exp=0", o_remaining); end
        n_vec++; if (ack_high_eject !== 0) begin n_err++; $display("FAIL p17_eject_during_ack got=%0d exp=0", ack_high_eject); end
    endtask

    task automatic test_short_inventory();
        load_coin(2'b10, 8'd0);
        load_coin(2'b01, 8'd1);
        load_coin(2'b00, 8'd1);
        run_payout(5'd8, 2, 1, 0, 200);
        n_vec++; if (ej_seq.size() !== 2) begin n_err++; $display("FAIL p8_ncoins got=%0d exp=2", ej_seq.size()); end
        n_vec++; if (ej_seq.size() == 2 && (ej_seq[0] !== 3'b010 || ej_seq[1] !== 3'b001)) begin n_err++; $display("FAIL p8_coins got=%b,%b exp=010,001", ej_seq[0], ej_seq[1]); end
        n_vec++; if (fail_seen !== 1'b1 || done_seen !== 1'b0) begin n_err++; $display("FAIL p8_fail got fail=%0d done=%0d exp fail=1 done=0", fail_seen, done_seen); end
        n_vec++; if (o_remaining !== 5'd2) begin n_err++; $display("FAIL p8_remaining got=%0d exp=2", o_remaining); end
        n_vec++; if ({o_cnt_5, o_cnt_1} !== 16'd0) begin n_err++; $display("FAIL p8_counts got=%0d/%0d exp=0/0", o_cnt_5, o_cnt_1); end
        n_vec++; if (o_jam !== 1'b0) begin n_err++; $display("FAIL p8_jam got=%0b exp=0", o_jam); end
    endtask

    task automatic test_zero_amount();
        load_coin(2'b00, 8'd4);
        i_load     = 1'b1;
        i_load_sel = 2'b00;
        i_load_cnt = 8'd200;
        run_payout(5'd0, 1, 1, 0, 20);
        n_vec++; if (eject_cycles !== 0) begin n_err++; $display("FAIL p0_eject got=%0d cycles exp=0", eject_cycles); end
        n_vec++; if (done_cycle !== 2) begin n_err++; $display("FAIL p0_done_latency got=%0d exp=2", done_cycle); end
        n_vec++; if (busy_cycles !== 2) begin n_err++; $display("FAIL p0_busy_cycles got=%0d exp=2", busy_cycles); end
        n_vec++; if (o_cnt_1 !== 8'd4) begin n_err++; $display("FAIL p0_load_with_start got=%0d exp=4", o_cnt_1); end
        n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL p0_idle got busy=%0b exp=0", o_busy); end
    endtask

    task automatic test_jam();
        load_coin(2'b00, 8'd3);
        run_payout(5'd1, 0, 0, 0, 400);
        n_vec++; if (eject_cycles !== 255) begin n_err++; $display("FAIL jam_eject_cycles got=%0d exp=255", eject_cycles); end
        n_vec++; if (fail_seen !== 1'b1) begin n_err++; $display("FAIL jam_fail got=%0d exp=1", fail_seen); end
        n_vec++; if (o_jam !== 1'b1) begin n_err++; $display("FAIL jam_flag got=%0b exp=1", o_jam); end
        n_vec++; if (o_cnt_1 !== 8'd3 || o_remaining !== 5'd1) begin n_err++; $display("FAIL jam_state got cnt_1=%0d rem=%0d exp cnt_1=3 rem=1", o_cnt_1, o_remaining); end
        i_amount = 5'd0;
        i_start  = 1'b1;
        step();
        i_start = 1'b0;
        n_vec++; if (o_jam !== 1'b0) begin n_err++; $display("FAIL jam_clear got=%0b exp=0", o_jam); end
        step();
        step();
        $display("jam cleared by restart, busy=%0b", o_busy);
    endtask

    task automatic test_ack_hold();
        load_coin(2'b10, 8'd0);
        load_coin(2'b01, 8'd0);
        load_coin(2'b00, 8'd4);
        run_payout(5'd2, 2, 5, 1, 200);
        n_vec++; if (ej_seq.size() !== 2) begin n_err++; $display("FAIL hold_ncoins got=%0d exp=2", ej_seq.size()); end
        n_vec++; if (done_seen !== 1'b1) begin n_err++; $display("FAIL hold_done got=%0d exp=1", done_seen); end
        n_vec++; if (o_cnt_1 !== 8'd2) begin n_err++; $display("FAIL hold_cnt_1 got=%0d exp=2", o_cnt_1); end
        n_vec++; if (o_remaining !== 5'd0) begin n_err++; $display("FAIL hold_remaining got=%0d exp=0", o_remaining); end
        n_vec++; if (ack_high_eject !== 0) begin n_err++; $display("FAIL hold_eject_during_ack got=%0d exp=0", ack_high_eject); end
    endtask

    task automatic test_reset_mid_payout();
        load_coin(2'b00, 8'd3);
        i_amount = 5'd1;
        i_start  = 1'b1;
        step();
        i_start = 1'b0;
        step();
        n_vec++; if (o_eject !== 3'b001) begin n_err++; $display("FAIL rst_pre_eject got=%b exp=001", o_eject); end
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++; if ({o_eject, o_busy, o_done, o_fail, o_jam} !== 7'd0) begin n_err++; $display("FAIL rst_async_outputs got=%b exp=0000000", {o_eject, o_busy, o_done, o_fail, o_jam}); end
        n_vec++; if ({o_remaining, o_cnt_1, o_cnt_5, o_cnt_10} !== 29'd0) begin n_err++; $display("FAIL rst_async_regs got rem=%0d c1=%0d exp 0", o_remaining, o_cnt_1); end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        step();
        n_vec++; if (o_busy !== 1'b0 || o_eject !== 3'b000) begin n_err++; $display("FAIL rst_after_idle got busy=%0b eject=%b exp 0/000", o_busy, o_eject); end
        n_vec++; if (o_cnt_1 !== 8'd0) begin n_err++; $display("FAIL rst_after_cnt_1 got=%0d exp=0", o_cnt_1); end
        $display("reset during eject: busy=%0b cnt_1=%0d", o_busy, o_cnt_1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n      = 1'b0;
        i_start      = 1'b0;
        i_amount     = 5'd0;
        i_hopper_ack = 1'b0;
        i_load       = 1'b0;
        i_load_sel   = 2'b11;
        i_load_cnt   = 8'd0;
        test_reset();
        test_load();
        test_payout_17();
        test_short_inventory();
        test_zero_amount();
        test_jam();
        test_ack_hold();
        test_reset_mid_payout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
